// File: rtl/multiword_add_pkg.sv
// Shared types and helpers for the multi-word adder sequencer.
// Holds the slice width, the FSM state type and the slice-index width helper.
package multiword_add_pkg;

    localparam int unsigned SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ADD_AB,
        ADD_CIN,
        DONE
    } state_e;

    // Keep at least one index bit so WORDS=1 still has a legal vector.
    function automatic int unsigned idx_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/multiword_add_sequencer.sv
// Runs a WORDS x 16-bit add on one shared external 16-bit adder, LSB slice first.
// Optional macro MULTIWORD_ADD_SKIP_ZERO_CARRY_EN skips the carry pass when the carry-in is 0.
module multiword_add_sequencer
    import multiword_add_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [SLICE_W*WORDS-1:0]   op_a_i,
    input  logic [SLICE_W*WORDS-1:0]   op_b_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [SLICE_W*WORDS-1:0]   sum_o,
    output logic                       carry_o,
    output logic [SLICE_W-1:0]         adder_a_o,
    output logic [SLICE_W-1:0]         adder_b_o,
    input  logic [SLICE_W:0]           adder_sum_i
);

    localparam int unsigned W     = SLICE_W * WORDS;
    localparam int unsigned IDX_W = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_res;
    logic [W-1:0]     r_sum;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic             r_c1;
    logic             r_cy;

    logic             w_accept;
    logic             w_last;
    logic             w_skip;
    logic [W-1:0]     w_res_next;

    assign w_accept = in_valid_i & in_ready_o;
    assign w_last   = (r_idx == LAST_IDX);

`ifdef MULTIWORD_ADD_SKIP_ZERO_CARRY_EN
    assign w_skip = ~r_cy;
`else
    assign w_skip = 1'b0;
`endif

    // Result register with the current slice replaced by the adder output.
    always_comb begin
        w_res_next = r_res;
        w_res_next[r_idx*SLICE_W +: SLICE_W] = adder_sum_i[SLICE_W-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_next = ADD_AB;
            ADD_AB: begin
                if (!w_skip)     w_state_next = ADD_CIN;
                else if (w_last) w_state_next = DONE;
                else             w_state_next = ADD_AB;
            end
            ADD_CIN: w_state_next = w_last ? DONE : ADD_AB;
            DONE:    if (out_ready_i) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (r_state == IDLE);
        out_valid_o = (r_state == DONE);
        adder_a_o   = '0;
        adder_b_o   = '0;
        unique case (r_state)
            ADD_AB: begin
                adder_a_o = r_a[r_idx*SLICE_W +: SLICE_W];
                adder_b_o = r_b[r_idx*SLICE_W +: SLICE_W];
            end
            ADD_CIN: begin
                adder_a_o = r_res[r_idx*SLICE_W +: SLICE_W];
                adder_b_o = {{(SLICE_W-1){1'b0}}, r_cy};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_c1    <= 1'b0;
            r_cy    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a   <= op_a_i;
                        r_b   <= op_b_i;
                        r_res <= '0;
                        r_idx <= '0;
                        r_c1  <= 1'b0;
                        r_cy  <= 1'b0;
                    end
                end
                ADD_AB: begin
                    r_res <= w_res_next;
                    r_c1  <= adder_sum_i[SLICE_W];
                    if (w_skip) begin
                        r_cy <= adder_sum_i[SLICE_W];
                        if (w_last) begin
                            r_sum   <= w_res_next;
                            r_carry <= adder_sum_i[SLICE_W];
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ADD_CIN: begin
                    r_res <= w_res_next;
                    // A+B and partial+carry can never both carry out.
                    r_cy  <= r_c1 | adder_sum_i[SLICE_W];
                    if (w_last) begin
                        r_sum   <= w_res_next;
                        r_carry <= r_c1 | adder_sum_i[SLICE_W];
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum_o   = r_sum;
    assign carry_o = r_carry;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed and random checks of multiword_add_sequencer with a behavioural 16-bit adder.
// Expected latencies follow MULTIWORD_ADD_SKIP_ZERO_CARRY_EN when it is defined.
module tb_multiword_add_sequencer;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 16 * WORDS;
    localparam int          BOUND = 4 * WORDS + 10;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          carry;
    logic [15:0]   adder_a;
    logic [15:0]   adder_b;
    logic [16:0]   adder_sum;

    int n_checks;
    int n_fail;

    assign adder_sum = {1'b0, adder_a} + {1'b0, adder_b};

    multiword_add_sequencer #(
        .WORDS (WORDS)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .carry_o     (carry),
        .adder_a_o   (adder_a),
        .adder_b_o   (adder_b),
        .adder_sum_i (adder_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
        int   lat;
        logic cy;
        logic [16:0] s;
        lat = 0;
        cy  = 1'b0;
        for (int i = 0; i < int'(WORDS); i++) begin
            s = {1'b0, a[i*16 +: 16]} + {1'b0, b[i*16 +: 16]} + {16'b0, cy};
`ifdef MULTIWORD_ADD_SKIP_ZERO_CARRY_EN
            lat += cy ? 2 : 1;
`else
            lat += 2;
`endif
            cy = s[16];
        end
        return lat;
    endfunction

    // Accept one operand pair and count edges until out_valid (bounded).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < BOUND) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pop_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        n_checks++;
        if (sum !== '0 || carry !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sum: sum=%h carry=%b required 0/0", sum, carry);
        end
        n_checks++;
        if (adder_a !== 16'h0 || adder_b !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_adder: a=%h b=%h required 0/0", adder_a, adder_b);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: in_ready=%b out_valid=%b", in_ready, out_valid);
        end
    endtask

    task automatic test_vector(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W:0] exp, input int exp_l);
        int lat;
        run_op(a, b, lat);
        n_checks++;
        if (out_valid !== 1'b1 || lat != exp_l) begin
            n_fail++;
            $display("FAIL %s_latency: out_valid=%b lat=%0d required 1/%0d", name, out_valid,
                     lat, exp_l);
        end
        n_checks++;
        if ({carry, sum} !== exp) begin
            n_fail++;
            $display("FAIL %s_result: got %h required %h", name, {carry, sum}, exp);
        end
        n_checks++;
        if (in_ready !== 1'b0 || adder_a !== 16'h0 || adder_b !== 16'h0) begin
            n_fail++;
            $display("FAIL %s_done_outputs: in_ready=%b a=%h b=%h required 0/0/0", name,
                     in_ready, adder_a, adder_b);
        end
        pop_result();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_pop: out_valid=%b in_ready=%b required 0/1", name, out_valid,
                     in_ready);
        end
    endtask

    task automatic test_ripple();
`ifdef MULTIWORD_ADD_SKIP_ZERO_CARRY_EN
        test_vector("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001,
                    65'h1_0000_0000_0000_0000, 7);
`else
        test_vector("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001,
                    65'h1_0000_0000_0000_0000, 8);
`endif
    endtask

    task automatic test_no_carry();
`ifdef MULTIWORD_ADD_SKIP_ZERO_CARRY_EN
        test_vector("no_carry", 64'h0001_0002_0003_0004, 64'h1111_1111_1111_1111,
                    65'h0_1112_1113_1114_1115, 4);
`else
        test_vector("no_carry", 64'h0001_0002_0003_0004, 64'h1111_1111_1111_1111,
                    65'h0_1112_1113_1114_1115, 8);
`endif
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, lat);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_valid: out_valid=%b required 1", out_valid);
        end
        @(negedge clk);
        in_valid = 1'b1;
        op_a     = 64'h0000_0000_0000_0001;
        op_b     = 64'h0000_0000_0000_0001;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {carry, sum} !== 65'h1_1111_1111_1111_1100) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: valid=%b ready=%b result=%h required 1/0/%h", i,
                         out_valid, in_ready, {carry, sum}, 65'h1_1111_1111_1111_1100);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || adder_a !== 16'h0) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b ready=%b adder_a=%h required 0/1/0", out_valid,
                     in_ready, adder_a);
        end
        test_vector("bp_next", 64'd3, 64'd4, 65'd7, exp_lat(64'd3, 64'd4));
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1;
        op_a     = 64'hFFFF_FFFF_FFFF_FFFF;
        op_b     = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || adder_a !== 16'h0 || adder_b !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b ready=%b a=%h b=%h required 0/1/0/0", out_valid,
                     in_ready, adder_a, adder_b);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < int'(2 * WORDS + 4); i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL mid_reset_idle_%0d: valid=%b ready=%b required 0/1", i,
                         out_valid, in_ready);
            end
        end
        test_vector("after_reset", 64'd5, 64'd7, 65'h0_0000_0000_0000_000C,
                    exp_lat(64'd5, 64'd7));
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   exp;
        int           lat;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < int'(WORDS); i++) begin
                a[i*16 +: 16] = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom);
                b[i*16 +: 16] = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom);
            end
            exp = {1'b0, a} + {1'b0, b};
            run_op(a, b, lat);
            n_checks++;
            if (out_valid !== 1'b1 || lat != exp_lat(a, b) || {carry, sum} !== exp) begin
                n_fail++;
                $display("FAIL random_%0d: a=%h b=%h got %h lat=%0d required %h lat=%0d", n,
                         a, b, {carry, sum}, lat, exp, exp_lat(a, b));
            end
            pop_result();
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        test_reset();
        test_ripple();
        test_no_carry();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
